// File: rtl/adc_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_fifo
// Description : Captures 12-bit offset-binary ADC samples on each rising edge
//               of the receiver done flag, converts them to signed Q1.15 and
//               buffers them in a small FIFO that feeds the filter bank over
//               a valid/accept handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock44kHz     in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   dato_in        in   DATA_W offset-binary sample, stable while listo_in high
//   listo_in       in   receiver done level; one push per rising edge
//   muestra_out    out  OUT_W head-of-FIFO sample (Q1.15), 0 when empty
//   valido_out     out  FIFO non-empty
//   acepta_in      in   consumer takes the head this cycle
//   nivel          out  occupancy 0..DEPTH
//   desborde       out  sticky overflow flag
//   clear_desborde in   synchronous clear of desborde (a same-cycle set wins)
// ============================================================================
module adc_sample_fifo #(
    parameter int DATA_W = 12,
    parameter int OUT_W  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock44kHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] dato_in,
    input  logic              listo_in,
    output logic [OUT_W-1:0]  muestra_out,
    output logic              valido_out,
    input  logic              acepta_in,
    output logic [ADDR_W:0]   nivel,
    output logic              desborde,
    input  logic              clear_desborde
);

    localparam logic [ADDR_W:0]   c_full_lvl = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_lvl_one  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ptr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [OUT_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_nivel;
    logic              r_desborde;
    logic              r_listo_prev;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_write;
    logic              w_drop;
    logic              w_valid;
    logic [OUT_W-1:0]  w_conv;

    // Rising-edge detect on the done level. The history register resets to 1
    // so a level already high when reset is released is not taken as new.
    assign w_push  = listo_in & ~r_listo_prev;
    assign w_valid = (r_nivel != '0);
    assign w_pop   = w_valid & acepta_in;
    assign w_full  = (r_nivel == c_full_lvl);
    // When full, a push only fits if the head leaves in the same cycle.
    assign w_write = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Offset binary to two's complement is an MSB flip; then left-align the
    // sample in the Q1.15 word with zero LSBs.
    assign w_conv = {~dato_in[DATA_W-1], dato_in[DATA_W-2:0], {(OUT_W-DATA_W){1'b0}}};

    always_ff @(posedge clock44kHz or negedge reset) begin
        if (!reset) begin
            r_listo_prev <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_nivel      <= '0;
            r_desborde   <= 1'b0;
        end else begin
            r_listo_prev <= listo_in;

            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end

            case ({w_write, w_pop})
                2'b10:   r_nivel <= r_nivel + c_lvl_one;
                2'b01:   r_nivel <= r_nivel - c_lvl_one;
                default: r_nivel <= r_nivel;
            endcase

            if (w_drop) begin
                r_desborde <= 1'b1;
            end else if (clear_desborde) begin
                r_desborde <= 1'b0;
            end
        end
    end

    // Storage needs no reset: the output is masked while the FIFO is empty.
    always_ff @(posedge clock44kHz) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_conv;
        end
    end

    assign valido_out  = w_valid;
    assign muestra_out = w_valid ? r_mem[r_rd_ptr] : '0;
    assign nivel       = r_nivel;
    assign desborde    = r_desborde;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_sample_fifo
// Description : Directed self-checking bench for adc_sample_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_fifo;

    logic        clk;
    logic        rst_n;
    logic [11:0] dato_in;
    logic        listo_in;
    logic [15:0] muestra_out;
    logic        valido_out;
    logic        acepta_in;
    logic [3:0]  nivel;
    logic        desborde;
    logic        clear_desborde;

    int total;
    int bad;

    adc_sample_fifo #(
        .DATA_W(12),
        .OUT_W (16),
        .DEPTH (8),
        .ADDR_W(3)
    ) dut (
        .clock44kHz    (clk),
        .reset         (rst_n),
        .dato_in       (dato_in),
        .listo_in      (listo_in),
        .muestra_out   (muestra_out),
        .valido_out    (valido_out),
        .acepta_in     (acepta_in),
        .nivel         (nivel),
        .desborde      (desborde),
        .clear_desborde(clear_desborde)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs and checks happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] v);
        dato_in  = v;
        listo_in = 1'b1;
        step();
        listo_in = 1'b0;
        step();
    endtask

    task automatic pop_one();
        acepta_in = 1'b1;
        step();
        acepta_in = 1'b0;
    endtask

    task automatic drain_check(input string tag, input logic [15:0] exp);
        check(tag, 32'(valido_out), 32'd1);
        check(tag, 32'(muestra_out), 32'(exp));
        pop_one();
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        dato_in        = '0;
        listo_in       = 1'b0;
        acepta_in      = 1'b0;
        clear_desborde = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_nivel", 32'(nivel), 32'd0);
        check("rst_valido", 32'(valido_out), 32'd0);
        check("rst_muestra", 32'(muestra_out), 32'h0);
        check("rst_desborde", 32'(desborde), 32'd0);
        rst_n = 1'b1;
        step();

        // Single sample held high for 20 cycles: exactly one push
        dato_in  = 12'h555;
        listo_in = 1'b1;
        check("pre_edge_valido", 32'(valido_out), 32'd0);
        step();
        check("single_nivel", 32'(nivel), 32'd1);
        check("single_valido", 32'(valido_out), 32'd1);
        check("single_muestra", 32'(muestra_out), 32'hD550);
        repeat (19) step();
        check("held_nivel", 32'(nivel), 32'd1);
        listo_in = 1'b0;
        step();
        pop_one();
        check("single_pop_nivel", 32'(nivel), 32'd0);
        check("single_pop_valido", 32'(valido_out), 32'd0);
        check("single_pop_muestra", 32'(muestra_out), 32'h0);

        // Acceptance while empty is ignored
        pop_one();
        check("empty_accept_nivel", 32'(nivel), 32'd0);

        // Conversion corners
        push(12'h000);
        push(12'h800);
        push(12'hFFF);
        push(12'h7FF);
        check("corner_nivel", 32'(nivel), 32'd4);
        drain_check("corner_000", 16'h8000);
        drain_check("corner_800", 16'h0000);
        drain_check("corner_FFF", 16'h7FF0);
        drain_check("corner_7FF", 16'hFFF0);
        check("corner_empty", 32'(valido_out), 32'd0);

        // Overflow: nine pushes into eight entries
        for (int i = 1; i <= 9; i++) push(12'(i));
        check("ovf_nivel", 32'(nivel), 32'd8);
        check("ovf_desborde", 32'(desborde), 32'd1);
        clear_desborde = 1'b1;
        step();
        clear_desborde = 1'b0;
        check("ovf_clear", 32'(desborde), 32'd0);
        for (int i = 1; i <= 8; i++) drain_check("ovf_drain", 16'h8000 | 16'(i << 4));
        check("ovf_empty_nivel", 32'(nivel), 32'd0);
        check("ovf_empty_valido", 32'(valido_out), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 8; i++) push(12'(i));
        check("fullpp_pre_nivel", 32'(nivel), 32'd8);
        dato_in   = 12'h00A;
        listo_in  = 1'b1;
        acepta_in = 1'b1;
        step();
        acepta_in = 1'b0;
        listo_in  = 1'b0;
        check("fullpp_nivel", 32'(nivel), 32'd8);
        check("fullpp_desborde", 32'(desborde), 32'd0);
        step();
        for (int i = 2; i <= 8; i++) drain_check("fullpp_drain", 16'h8000 | 16'(i << 4));
        drain_check("fullpp_last", 16'h80A0);
        check("fullpp_empty", 32'(nivel), 32'd0);

        // Pointer wrap with interleaved push/pop
        for (int i = 0; i < 20; i++) begin
            push(12'(12'h100 + i));
            check("wrap_nivel", 32'(nivel), 32'd1);
            drain_check("wrap_data", 16'((32'h100 + i) ^ 32'h800) << 4);
            check("wrap_after_pop", 32'(nivel), 32'd0);
        end

        // Clear coinciding with a dropped push: set wins
        for (int i = 1; i <= 8; i++) push(12'(i));
        dato_in        = 12'h009;
        listo_in       = 1'b1;
        clear_desborde = 1'b1;
        step();
        clear_desborde = 1'b0;
        listo_in       = 1'b0;
        check("setwins_desborde", 32'(desborde), 32'd1);
        check("setwins_nivel", 32'(nivel), 32'd8);
        step();
        repeat (3) pop_one();
        check("pre_rst_nivel", 32'(nivel), 32'd5);

        // Asynchronous reset mid-operation with listo_in held high
        listo_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_nivel", 32'(nivel), 32'd0);
        check("midrst_valido", 32'(valido_out), 32'd0);
        check("midrst_desborde", 32'(desborde), 32'd0);
        check("midrst_muestra", 32'(muestra_out), 32'h0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("held_through_rst", 32'(nivel), 32'd0);
        listo_in = 1'b0;
        dato_in  = 12'h123;
        step();
        listo_in = 1'b1;
        step();
        check("post_rst_push_nivel", 32'(nivel), 32'd1);
        check("post_rst_push_data", 32'(muestra_out), 32'h9230);
        listo_in = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
